// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared state encoding, constants and helpers for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [29:0] DEFAULT_RESET_PC = 30'h0010_0000;

    // Byte address of the instruction after the one at word address pc; wraps naturally.
    function automatic logic [31:0] pc4_of(input logic [29:0] pc);
        return {pc + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/if_de_reg.sv
// rtl/if_de_reg.sv - IF/DE pipeline register with load enable and bubble insert
module if_de_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_en,
    input  logic        i_bubble,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc4
);

    always_ff @(posedge clk) begin
        if (!resetn || i_bubble) begin
            o_valid <= 1'b0;
            o_inst  <= NOP_INST;
            o_pc4   <= 32'h0;
        end else if (i_en) begin
            o_valid <= 1'b1;
            o_inst  <= i_inst;
            o_pc4   <= i_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem request FSM and IF/DE load; FETCH_PERF_EN adds fetch/flush counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        de_valid,
    output logic [31:0] de_inst,
    output logic [31:0] de_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    fetch_state_t r_state;
    logic [29:0]  r_pc;
    logic [29:0]  r_shadow;
    logic [31:0]  r_buf;

    logic         w_load;
    logic         w_bubble;
    logic [31:0]  w_load_inst;

    assign imem_req  = reset && (r_state != HOLD);
    // In DISCARD the stale request must stay on the bus while pc already holds the target.
    assign imem_addr = (r_state == DISCARD) ? r_shadow : r_pc;

    always_comb begin
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_load_inst = imem_rdata;
        case (r_state)
            FETCH: begin
                if (redirect)                  w_bubble = 1'b1;
                else if (imem_ready && !stall) w_load   = 1'b1;
            end
            HOLD: begin
                w_load_inst = r_buf;
                if (redirect)    w_bubble = 1'b1;
                else if (!stall) w_load   = 1'b1;
            end
            DISCARD: begin
                if (redirect) w_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_shadow <= RESET_PC;
            r_buf    <= NOP_INST;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                        if (!imem_ready) begin
                            r_shadow <= r_pc;
                            r_state  <= DISCARD;
                        end
                    end else if (imem_ready) begin
                        if (!stall) begin
                            r_pc <= r_pc + 30'd1;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_buf   <= NOP_INST;
                        r_state <= FETCH;
                    end else if (!stall) begin
                        r_pc    <= r_pc + 30'd1;
                        r_state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect)   r_pc    <= redirect_pc;
                    // A response arriving with a new redirect still closes the stale request.
                    if (imem_ready) r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    if_de_reg u_if_de_reg (
        .clk      (clk),
        .resetn   (reset),
        .i_en     (w_load),
        .i_bubble (w_bubble),
        .i_inst   (w_load_inst),
        .i_pc4    (pc4_of(r_pc)),
        .o_valid  (de_valid),
        .o_inst   (de_inst),
        .o_pc4    (de_pc4)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (w_load)
                fetch_count <= fetch_count + 32'd1;
            if (w_bubble && (de_valid || r_state == HOLD))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS machine: owns the PC, issues word-address requests to instruction memory, and loads the IF/DE pipeline register consumed by decode. It supports single-outstanding, variable-latency memory, decode stalls, and redirects from branches and jumps resolved in DE. Memory data returned while decode is stalled goes into a one-entry hold buffer. Stale responses after a redirect are discarded.

## Interface
- RESET_PC, default 30'h0010_0000 (byte address 0x0040_0000): word address loaded into the PC at reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
- imem_req  out  1  fetch request valid
- imem_addr  out  30  word address of the request (byte address = {imem_addr, 2'b00})
- imem_ready  in  1  imem_rdata valid this cycle; tie to 1 for a zero-latency memory
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept; hold IF/DE
- redirect  in  1  branch/jump taken in DE; flush and refetch
- redirect_pc  in  30  word-address target, sampled when redirect==1
- de_valid  out  1  IF/DE holds a real instruction
- de_inst  out  32  IF/DE instruction (32'h0 = nop when invalid)
- de_pc4  out  32  byte address of fetched instruction + 4

## Operation
- FSM states: FETCH, HOLD, DISCARD. Reset state is FETCH.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc.
  - redirect: pc<=redirect_pc and IF/DE<=bubble (valid 0, inst 0, pc4 0).
    - If imem_ready=1, drop the data and stay in FETCH.
    - Otherwise go to DISCARD.
  - imem_ready & !stall: IF/DE<={1, imem_rdata, {pc+1,2'b00}}; pc<=pc+1; stay in FETCH.
  - imem_ready & stall: buffer<=imem_rdata; IF/DE unchanged; go to HOLD.
  - !imem_ready: nothing changes; imem_addr must stay stable.
- HOLD:
  - Outputs: imem_req=0, imem_addr=pc.
  - redirect: pc<=redirect_pc; IF/DE<=bubble; buffer dropped; go to FETCH.
  - !stall: IF/DE<={1, buffer, {pc+1,2'b00}}; pc<=pc+1; go to FETCH.
  - stall: hold.
- DISCARD:
  - Outputs: imem_req=1, imem_addr=old address held in a shadow register; pc already holds the target.
  - imem_ready: drop the data; go to FETCH.
  - A further redirect updates pc and stays in DISCARD.
- Priority: reset > redirect > stall > advance. If redirect and stall are both asserted, redirect wins.
- stall holds all IF/DE fields bit-for-bit.
- pc+1 wraps modulo 2^30; de_pc4 wraps modulo 2^32.

## Timing
- Reset values:
  - pc=RESET_PC; state FETCH; de_valid=0, de_inst=0, de_pc4=0; buffer empty.
  - imem_req=0 combinationally while reset==0.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Latency: imem_rdata sampled at edge N appears on de_inst after edge N (one cycle).
- Throughput: one instruction per cycle with imem_ready tied high and no stall.
- Redirect: bubble visible after the same edge; target address is driven the next cycle (FETCH), or after the stale response (DISCARD).
- Reset mid-operation, any state: returns to the reset values at that edge. The in-flight request is abandoned; the memory must tolerate this.
- Exactly one outstanding request. A response is never accepted while imem_req==0.

## Configuration
- FETCH_PERF_EN defined: adds ports fetch_count out 32 and flush_count out 32.
  - fetch_count increments on each IF/DE load with valid=1.
  - flush_count increments on each redirect that replaces a valid IF/DE entry or a held buffer.
  - Both reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - state encoding (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2)
  - NOP_INST=32'h0
  - default RESET_PC
- One sub-module: if_de_reg, the IF/DE register.
  - Inputs: synchronous active-low reset, enable, bubble-insert.
  - Fields: valid, inst, pc4.
  - Instantiated once.

## Test plan
- Reset, then imem_ready=1 with memory returning addr^32'hA5A5_0000, no stall:
  - imem_addr = 0x100000, 0x100001, 0x100002 on consecutive cycles.
  - de_pc4 = 0x0040_0004, 0x0040_0008; de_valid=1 from the second cycle.
- stall for 3 cycles while imem_ready=1:
  - IF/DE unchanged for 3 cycles; state HOLD; imem_req=0.
  - After stall drops, the buffered word appears once, with no loss or duplicate.
- redirect with redirect_pc=0x100040 while imem_ready=0 (request pending at 0x100005):
  - imem_addr stays 0x100005 until imem_ready.
  - That response is dropped; next request is 0x100040; de_valid=0 meanwhile.
- redirect and stall asserted together in HOLD:
  - bubble loaded, buffer dropped, next fetch at redirect_pc.
  - With FETCH_PERF_EN, flush_count increments by 1.
- reset=0 for one edge during DISCARD:
  - pc=0x100000, de_valid=0, next cycle imem_req=1 at 0x100000.
  - Counters (FETCH_PERF_EN) read 0.
- PC wrap: RESET_PC=30'h3FFF_FFFF, one fetch → imem_addr=0, de_pc4=32'h0.
